// File: rtl/wptr_full_prog.sv
// wptr_full_prog: FIFO write pointer with full, programmable almost-full and fill level; `WPTR_FULL_OVERFLOW_EN adds a sticky overflow flag
module wptr_full_prog #(
    parameter int                ADDRSIZE  = 4,
    parameter logic [ADDRSIZE:0] AFULL_RST = (ADDRSIZE+1)'((1 << ADDRSIZE) - 1)
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                thr_we,
    input  logic [ADDRSIZE:0]   thr_wdata,
`ifdef WPTR_FULL_OVERFLOW_EN
    input  logic                wovf_clr,
    output logic                wovf,
`endif
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                awfull,
    output logic [ADDRSIZE:0]   wlevel
);
    logic [ADDRSIZE:0] wbin, wbinnext, wgraynext, rbin, lvl_next, thr;
    logic              full_next;
    assign wbinnext  = wbin + (ADDRSIZE+1)'(winc & ~wfull);
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;
    assign waddr     = wbin[ADDRSIZE-1:0];
    // each binary bit is the XOR of all Gray bits at or above it
    for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_rbin
        assign rbin[i] = ^wq2_rptr[ADDRSIZE:i];
    end
    assign lvl_next  = wbinnext - rbin;
    assign full_next = wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            awfull <= 1'b0;
            wlevel <= '0;
            thr    <= AFULL_RST;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wfull  <= full_next;
            awfull <= lvl_next >= thr;
            wlevel <= lvl_next;
            thr    <= thr_we ? thr_wdata : thr;
        end
    end
`ifdef WPTR_FULL_OVERFLOW_EN
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) wovf <= 1'b0;
        else      wovf <= (winc & wfull) | (wovf & ~wovf_clr);
    end
`endif
endmodule

// File: doc/wptr_full_prog.md
Name: wptr_full_prog

Overview:
- Next-generation write-side pointer/flag controller for the FIFO library.
- Keeps the binary write pointer and Gray-coded write pointer, and decodes the already-synchronised Gray read pointer.
- Produces full, a programmable almost-full, and a registered fill level.
- Sits between the write client and the dual-port RAM, in the write clock domain; the read-pointer synchroniser is external.

Parameters:
- ADDRSIZE, 4, RAM address width; DEPTH = 2**ADDRSIZE entries; legal range >= 2.
- AFULL_RST, 2**ADDRSIZE - 1, reset/default value of the internal almost-full threshold register.

Ports:
- wclk  in  1  write clock; all state updates on its rising edge.
- wrst  in  1  asynchronous reset, active-high. Assertion clears all state immediately; deassertion is assumed synchronous to wclk.
- winc  in  1  write request; a write is accepted when winc=1 and wfull=0.
- wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already synchronised into wclk.
- thr_we  in  1  load almost-full threshold.
- thr_wdata  in  ADDRSIZE+1  new threshold value, 0..DEPTH.
- waddr  out  ADDRSIZE  RAM write address = wbin[ADDRSIZE-1:0].
- wptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
- wfull  out  1  registered full flag.
- awfull  out  1  registered almost-full flag.
- wlevel  out  ADDRSIZE+1  registered occupancy, 0..DEPTH.

Behaviour:
- Reset values (wrst=1, asynchronous):
  - wbin=0, wptr=0, waddr=0.
  - wfull=0, awfull=0, wlevel=0.
  - Threshold register = AFULL_RST.
- Next-state logic:
  - wbinnext = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1).
  - wgraynext = (wbinnext>>1) ^ wbinnext.
  - The {wbin, wptr} registers load {wbinnext, wgraynext} every cycle.
- Read-pointer decode: rbin = Gray-to-binary(wq2_rptr), combinational (XOR prefix from the MSB down).
- Occupancy: lvl_next = (wbinnext - rbin) mod 2**(ADDRSIZE+1); wlevel <= lvl_next.
- Full:
  - wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - This must equal (lvl_next == DEPTH).
- Almost-full: awfull <= (lvl_next >= thr). Consequences:
  - thr=0: awfull=1 from the first clock after reset.
  - thr=DEPTH: awfull tracks wfull.
  - thr>DEPTH: awfull never asserts.
- Threshold load: thr_we=1 loads thr_wdata at the clock edge. The new value first affects awfull on the following edge (one extra cycle of latency).
- Latency: all flags and wlevel reflect the accepted write and the wq2_rptr sampled at the same edge, visible one cycle after that edge.
- winc while wfull=1:
  - The write is dropped.
  - wbin, wptr and waddr hold.
  - No RAM write enable may be derived from it; the top level uses winc & ~wfull.
- Simultaneous write and read-pointer advance: level = old + 1 - delta, computed in a single cycle, with no transient full.
- Wrap-around: wbin wraps from 2**(ADDRSIZE+1)-1 to 0; Gray wptr changes exactly one bit per accepted write, including at the wrap.
- Reset mid-operation: all outputs return to their reset values within the reset assertion, independent of wclk. The threshold register also reverts to AFULL_RST.

Optional Feature:
- Macro: WPTR_FULL_OVERFLOW_EN.
- With the macro defined:
  - Adds input wovf_clr (1 bit) and output wovf (1 bit, reset 0).
  - wovf is a sticky flag, set on the edge where winc=1 and wfull=1; wovf_clr=1 clears it.
  - If set and clear occur in the same cycle, set wins.
- Without the macro: neither port exists and dropped writes are silent.

Test Plan:
- ADDRSIZE=3, thr=6, wq2_rptr=0, winc held for 10 cycles:
  - awfull rises on the edge after the 6th write.
  - wfull rises with wlevel=8; waddr holds at 0 and wptr=4'b1100.
  - Writes 9 and 10 are dropped; wovf=1 when WPTR_FULL_OVERFLOW_EN is defined.
- From full, step wq2_rptr Gray 0000->0001->0011 -> wfull drops the next cycle; wlevel goes 7 then 6; awfull stays 1 at wlevel=6.
- Threshold load thr_wdata=2 with wlevel=3 -> awfull=1 two edges after the thr_we pulse; then load 9 -> awfull=0 and never reasserts.
- Continuous winc with the read pointer following 2 cycles behind, for 40 cycles -> wbin wraps past 15; wptr differs in exactly one bit per accepted write; wfull never asserts.
- Simultaneous winc and read advance at wlevel=8 on the same edge -> wlevel stays 8 only if rbin is unchanged. With rbin+1 the write is still dropped (wfull was 1), so wlevel=7.
- wrst pulsed mid-burst (wlevel=5) without a wclk edge -> all outputs return to 0 immediately; after release the next write gives waddr=1 and wlevel=1.
